// File: rtl/reg_write_sequencer_pkg.sv
// reg_write_sequencer_pkg: shared state encoding and default widths for the register write sequencer
package reg_write_sequencer_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NREGS_DEF = 8;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
endpackage

// File: rtl/reg_write_sequencer_req_fifo.sv
// req_fifo: synchronous show-ahead FIFO holding {addr, data} write requests
module req_fifo #(
  parameter int W = 19,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // pointers wrap naturally at DEPTH; count tracks occupancy including simultaneous push/pop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  // storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: replays queued register writes as stable data plus a one-hot strobe for negedge-capturing registers
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int ADDR_W = 3,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  wr_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q, head_addr;
  logic [DATA_W-1:0] head_data;
  logic full, empty, pop, head_ok;
  logic [PW:0] count;
  req_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(req_valid),
    .pop(pop),
    .din({req_addr, req_data}),
    .dout({head_addr, head_data}),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign req_ready = !full;
  assign busy = count != '0 || state != IDLE;
  assign head_ok = 32'(head_addr) < NREGS;
  // pop whenever not mid-setup; bad addresses are dropped straight back to IDLE
  always_comb begin
    pop = state != SETUP && !empty;
    state_nx = state == SETUP ? STROBE : (pop && head_ok ? SETUP : IDLE);
  end
  // registered outputs keep data and strobe glitch-free ahead of the capturing negedge
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wr_data <= '0;
      wr_en <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop && head_ok) begin
        addr_q <= head_addr;
        wr_data <= head_data;
      end
      wr_en <= state_nx == STROBE ? NREGS'(1) << addr_q : '0;
      done <= state == STROBE;
      err <= pop && !head_ok;
    end
endmodule
